// File: rtl/fir_scheduler.sv
// Time-multiplexed stereo FIR: one shared MAC runs all left taps, then all right taps.
// Optional macro FIR_SAT_EN: saturate the result to DW bits instead of wrapping.
module fir_scheduler #(
   parameter int unsigned NTAPS = 8,
   parameter int unsigned DW    = 24,
   parameter int unsigned CW    = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sample_valid,
   input  logic [DW-1:0]             left_in,
   input  logic [DW-1:0]             right_in,
   input  logic                      coeff_we,
   input  logic [$clog2(NTAPS)-1:0]  coeff_addr,
   input  logic [CW-1:0]             coeff_wdata,
   input  logic                      overrun_clr,
   output logic [DW-1:0]             left_out,
   output logic [DW-1:0]             right_out,
   output logic                      out_valid,
   output logic                      busy,
   output logic                      overrun
);

   localparam int unsigned LG = $clog2(NTAPS);
   localparam int unsigned PW = DW + CW;
   localparam int unsigned AW = PW + LG;

   typedef enum logic [1:0] {IDLE = 2'd0, MAC_L = 2'd1, MAC_R = 2'd2} state_t;

   state_t state, state_next;

   logic signed [DW-1:0] hist_l [NTAPS];
   logic signed [DW-1:0] hist_r [NTAPS];
   logic signed [CW-1:0] coeff  [NTAPS];

   logic [LG-1:0]        wp, base, k, idx;
   logic signed [AW-1:0] acc, acc_sum;
   logic signed [PW-1:0] prod;
   logic signed [DW-1:0] hist_sel, res, left_res;

   logic last, accept, drop, mac_en, fin_l, fin_r, coeff_ok;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   assign last = (k == LG'(NTAPS - 1));

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (sample_valid) state_next = MAC_L;
         MAC_L:   if (last)         state_next = MAC_R;
         MAC_R:   if (last)         state_next = IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   // Control strobes decoded from the current state
   always_comb begin
      accept   = 1'b0;
      drop     = 1'b0;
      mac_en   = 1'b0;
      fin_l    = 1'b0;
      fin_r    = 1'b0;
      coeff_ok = 1'b0;
      unique case (state)
         IDLE: begin
            accept   = sample_valid;
            coeff_ok = coeff_we && !sample_valid;
         end
         MAC_L: begin
            mac_en = 1'b1;
            drop   = sample_valid;
            fin_l  = last;
         end
         MAC_R: begin
            mac_en = 1'b1;
            drop   = sample_valid;
            fin_r  = last;
         end
         default: ;
      endcase
   end

   // Tap index walks backwards from the newest sample, wrapping mod NTAPS
   assign idx      = base - k;
   assign hist_sel = (state == MAC_R) ? hist_r[idx] : hist_l[idx];
   assign prod     = PW'(coeff[k]) * PW'(hist_sel);
   assign acc_sum  = acc + AW'(prod);

`ifdef FIR_SAT_EN
   logic signed [AW-1:0] shifted;
   always_comb begin
      shifted = acc_sum >>> (CW - 1);
      if ((&shifted[AW-1:DW-1]) || !(|shifted[AW-1:DW-1]))
         res = shifted[DW-1:0];
      else if (shifted[AW-1])
         res = {1'b1, {(DW-1){1'b0}}};
      else
         res = {1'b0, {(DW-1){1'b1}}};
   end
`else
   assign res = DW'(acc_sum >>> (CW - 1));
`endif

   // Datapath, history, coefficient bank and status flags
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wp        <= '0;
         base      <= '0;
         k         <= '0;
         acc       <= '0;
         left_res  <= '0;
         left_out  <= '0;
         right_out <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         overrun   <= 1'b0;
         for (int i = 0; i < int'(NTAPS); i++) begin
            hist_l[i] <= '0;
            hist_r[i] <= '0;
            coeff[i]  <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         busy      <= (state_next != IDLE);

         if (accept) begin
            hist_l[wp] <= left_in;
            hist_r[wp] <= right_in;
            base       <= wp;
            wp         <= wp + LG'(1);
            k          <= '0;
            acc        <= '0;
         end else if (mac_en) begin
            k   <= k + LG'(1);
            acc <= fin_l ? '0 : acc_sum;
         end

         if (fin_l) left_res <= res;
         if (fin_r) begin
            left_out  <= left_res;
            right_out <= res;
            out_valid <= 1'b1;
         end

         if (coeff_ok) coeff[coeff_addr] <= coeff_wdata;

         // A drop in the same cycle as a clear keeps the flag set
         if (drop)             overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_scheduler.sv
// Directed bench for fir_scheduler: table of single-tap gain vectors plus
// hand-written sequences for impulse/wrap, saturation, overrun, back-to-back and async reset.
module tb_fir_scheduler;

   logic        clk;
   logic        reset;
   logic        sample_valid;
   logic [23:0] left_in, right_in;
   logic        coeff_we;
   logic [2:0]  coeff_addr;
   logic [15:0] coeff_wdata;
   logic        overrun_clr;
   logic [23:0] left_out, right_out;
   logic        out_valid, busy, overrun;

   int total = 0;
   int bad   = 0;

   fir_scheduler #(.NTAPS(8), .DW(24), .CW(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_valid(sample_valid),
      .left_in     (left_in),
      .right_in    (right_in),
      .coeff_we    (coeff_we),
      .coeff_addr  (coeff_addr),
      .coeff_wdata (coeff_wdata),
      .overrun_clr (overrun_clr),
      .left_out    (left_out),
      .right_out   (right_out),
      .out_valid   (out_valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] c;
      logic [23:0] l;
      logic [23:0] r;
      logic [23:0] el;
      logic [23:0] er;
   } vec_t;

   vec_t tbl [5];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic wcoef(input int a, input logic [15:0] d);
      coeff_we    = 1'b1;
      coeff_addr  = 3'(a);
      coeff_wdata = d;
      @(negedge clk);
      coeff_we = 1'b0;
   endtask

   // Start a sample at the current negedge and return at the negedge where out_valid is seen
   task automatic do_sample(input logic [23:0] l, input logic [23:0] r,
                            input bit we_same, input bit we_busy, output int lat);
      sample_valid = 1'b1;
      left_in      = l;
      right_in     = r;
      if (we_same) begin
         coeff_we = 1'b1; coeff_addr = 3'd0; coeff_wdata = 16'h0000;
      end
      @(negedge clk);
      sample_valid = 1'b0;
      coeff_we     = 1'b0;
      lat          = 1;
      if (we_busy) begin
         coeff_we = 1'b1; coeff_addr = 3'd0; coeff_wdata = 16'h0000;
         @(negedge clk);
         coeff_we = 1'b0;
         lat      = 2;
      end
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat, nov, ovc;

      tbl[0] = '{16'h4000, 24'h100000, 24'hF00000, 24'h080000, 24'hF80000};
      tbl[1] = '{16'h7FFF, 24'h000001, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
`ifdef FIR_SAT_EN
      tbl[2] = '{16'h8000, 24'h000123, 24'h800000, 24'hFFFEDD, 24'h7FFFFF};
`else
      tbl[2] = '{16'h8000, 24'h000123, 24'h800000, 24'hFFFEDD, 24'h800000};
`endif
      tbl[3] = '{16'h2000, 24'h000007, 24'hFFFFF9, 24'h000001, 24'hFFFFFE};
      tbl[4] = '{16'h0000, 24'h7FFFFF, 24'h123456, 24'h000000, 24'h000000};

      reset = 1'b0; sample_valid = 1'b0; left_in = '0; right_in = '0;
      coeff_we = 1'b0; coeff_addr = '0; coeff_wdata = '0; overrun_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_left_out", 32'(left_out), 0);
      chk("rst_right_out", 32'(right_out), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overrun", 32'(overrun), 0);
      reset = 1'b1;
      @(negedge clk);

      // Single-tap gain vectors: only coeff[0] is nonzero, so older history is invisible
      for (int i = 0; i < 5; i++) begin
         wcoef(0, tbl[i].c);
         do_sample(tbl[i].l, tbl[i].r, 1'b0, 1'b0, lat);
         chk($sformatf("gain%0d_lat", i), 32'(lat), 17);
         chk($sformatf("gain%0d_left", i), 32'(left_out), 32'(tbl[i].el));
         chk($sformatf("gain%0d_right", i), 32'(right_out), 32'(tbl[i].er));
         chk($sformatf("gain%0d_busy_at_ov", i), 32'(busy), 0);
         repeat (3) @(negedge clk);
      end

      // Impulse response: one tap per output, then silence once the impulse leaves history
      do_reset();
      for (int k = 0; k < 8; k++) wcoef(k, 16'(16'h0100 * (k + 1)));
      for (int n = 0; n < 9; n++) begin
         do_sample((n == 0) ? 24'h008000 : 24'h000000, 24'h000000, 1'b0, 1'b0, lat);
         chk($sformatf("imp%0d_lat", n), 32'(lat), 17);
         chk($sformatf("imp%0d_left", n), 32'(left_out),
             (n < 8) ? 32'(24'h000100 * (n + 1)) : 32'h0);
         repeat (5) @(negedge clk);
      end

      // Saturation: full-scale input through full-scale taps
      do_reset();
      for (int k = 0; k < 8; k++) wcoef(k, 16'h7FFF);
      for (int n = 0; n < 8; n++) begin
         do_sample(24'h7FFFFF, 24'h000000, 1'b0, 1'b0, lat);
         if (n == 0) chk("sat_first_left", 32'(left_out), 32'h007FFEFF);
         repeat (3) @(negedge clk);
      end
`ifdef FIR_SAT_EN
      chk("sat_eighth_left", 32'(left_out), 32'h007FFFFF);
`else
      chk("sat_eighth_left", 32'(left_out), 32'h00FFF7F8);
`endif
      chk("sat_eighth_right", 32'(right_out), 0);

      // Overrun: second pulse at t+5 (with a simultaneous clear) is dropped
      do_reset();
      wcoef(0, 16'h4000);
      wcoef(1, 16'h4000);
      sample_valid = 1'b1; left_in = 24'h000100; right_in = 24'h0;
      nov = 0; ovc = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         sample_valid = 1'b0;
         overrun_clr  = 1'b0;
         if (out_valid) begin
            nov++;
            ovc = c;
         end
         if (c == 1) chk("ovr_busy_t1", 32'(busy), 1);
         if (c == 5) begin
            chk("ovr_flag_t5", 32'(overrun), 0);
            sample_valid = 1'b1; left_in = 24'h100000; overrun_clr = 1'b1;
         end
         if (c == 6) chk("ovr_flag_t6", 32'(overrun), 1);
      end
      chk("ovr_num_out_valid", 32'(nov), 1);
      chk("ovr_out_valid_cycle", 32'(ovc), 17);
      chk("ovr_first_left", 32'(left_out), 32'h00000080);
      chk("ovr_sticky", 32'(overrun), 1);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      chk("ovr_cleared", 32'(overrun), 0);
      do_sample(24'h000200, 24'h0, 1'b0, 1'b0, lat);
      chk("ovr_hist1_left", 32'(left_out), 32'h00000180);
      repeat (3) @(negedge clk);
      do_sample(24'h000000, 24'h0, 1'b0, 1'b0, lat);
      chk("ovr_hist2_left", 32'(left_out), 32'h00000100);

      // Back-to-back and coefficient write guard
      do_reset();
      wcoef(0, 16'h4000);
      do_sample(24'h000400, 24'h000010, 1'b0, 1'b0, lat);
      chk("b2b_first_left", 32'(left_out), 32'h00000200);
      do_sample(24'h000800, 24'h000020, 1'b0, 1'b1, lat);
      chk("b2b_lat", 32'(lat), 17);
      chk("b2b_left", 32'(left_out), 32'h00000400);
      chk("b2b_right", 32'(right_out), 32'h00000010);
      repeat (2) @(negedge clk);
      do_sample(24'h001000, 24'h0, 1'b1, 1'b0, lat);
      chk("guard_same_cycle_left", 32'(left_out), 32'h00000800);
      repeat (2) @(negedge clk);
      do_sample(24'h002000, 24'h0, 1'b0, 1'b0, lat);
      chk("guard_coeff_kept_left", 32'(left_out), 32'h00001000);

      // Async reset in MAC_R: outputs clear without a clock edge
      repeat (2) @(negedge clk);
      sample_valid = 1'b1; left_in = 24'h004000; right_in = 24'h0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         sample_valid = (c == 3);
      end
      chk("arst_busy_before", 32'(busy), 1);
      chk("arst_overrun_before", 32'(overrun), 1);
      chk("arst_left_before", 32'(left_out), 32'h00001000);
      #2 reset = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_left_out", 32'(left_out), 0);
      chk("arst_right_out", 32'(right_out), 0);
      chk("arst_overrun", 32'(overrun), 0);
      @(negedge clk);
      reset = 1'b1;
      nov = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (out_valid) nov++;
      end
      chk("arst_no_out_valid", 32'(nov), 0);
      do_sample(24'h100000, 24'h100000, 1'b0, 1'b0, lat);
      chk("arst_after_lat", 32'(lat), 17);
      chk("arst_after_left", 32'(left_out), 0);
      chk("arst_after_right", 32'(right_out), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_scheduler.md
# fir_scheduler

Time-multiplexed stereo FIR controller between the `i2s` receiver and downstream processing. On each new stereo sample it stores left/right into circular history buffers. It then runs one shared multiply-accumulate unit over all taps, left channel first and right channel second, and presents both filtered results with a one-cycle valid pulse. It also owns the runtime-writable coefficient bank that configures the filter (e.g. EQ presets loaded from the MCU).

## Interface
- `NTAPS`, 8: taps per channel; power of two, 2..64.
- `DW`, 24: sample width, signed two's complement.
- `CW`, 16: coefficient width, signed Q1.15.
- `clk`  in  1  system clock (12 MHz).
- `reset`  in  1  asynchronous, active-low reset. Asserted when low.
- `sample_valid`  in  1  one-cycle pulse; `left_in`/`right_in` valid (driven by `i2s.newsample_valid`).
- `left_in`, `right_in`  in  DW  new samples.
- `coeff_we`  in  1  coefficient write strobe.
- `coeff_addr`  in  clog2(NTAPS)  tap index.
- `coeff_wdata`  in  CW  coefficient value.
- `overrun_clr`  in  1  clears `overrun`.
- `left_out`, `right_out`  out  DW  filtered results; held between updates.
- `out_valid`  out  1  one-cycle pulse when outputs update.
- `busy`  out  1  high while a computation is in progress.
- `overrun`  out  1  sticky flag: a sample was dropped.

## Operation
- Reset (reset low) forces the following values immediately:
  - All outputs are 0.
  - Both history buffers are 0.
  - Write pointer `wp` is 0.
  - All coefficients are 0.
  - The FSM is in IDLE.
- FSM states: IDLE, MAC_L, MAC_R.
- **IDLE:** if `sample_valid`:
  - write `left_in`/`right_in` at history index `wp`;
  - latch `base = wp`, then `wp <= wp+1` (wraps at NTAPS);
  - set `k = 0`, `acc = 0`, go to MAC_L.
- **MAC_L:** each cycle, `acc += coeff[k] * histL[(base-k) mod NTAPS]` and `k++`.
  - After tap NTAPS-1, latch the left result, clear `acc`, set `k = 0`, go to MAC_R.
- **MAC_R:** identical, using `histR`.
  - After tap NTAPS-1, register both results into `left_out`/`right_out` and pulse `out_valid`.
  - Return to IDLE.
- Arithmetic:
  - Product width is DW+CW.
  - Accumulator width is DW+CW+clog2(NTAPS); no internal overflow is possible.
  - Result = `acc >>> (CW-1)` (arithmetic shift, truncation toward −∞), reduced to DW bits per Configuration.
- `busy` is high in MAC_L and MAC_R.
- A `sample_valid` arriving while busy is dropped: history and `wp` are unchanged and `overrun` is set.
- `overrun` clears only on `overrun_clr` or reset. If `overrun_clr` and a drop occur in the same cycle, set wins.
- `coeff_we` is accepted only in IDLE with `sample_valid` low; otherwise the write is ignored.
- `sample_valid` and `coeff_we` together in IDLE: the sample is accepted and the write is ignored.

## Timing
- `sample_valid` sampled in cycle t → `busy` high in t+1 … t+2·NTAPS.
- `out_valid` high in cycle t+2·NTAPS+1, so latency is 2·NTAPS+1 (17 cycles at NTAPS=8).
- The FSM is in IDLE during the `out_valid` cycle, so a `sample_valid` in that same cycle is accepted.
- The sustained sample period must be at least 2·NTAPS+1 clk cycles; the I2S rate gives 256.
- History wrap: sample n−NTAPS is overwritten by sample n, so the impulse response is exactly NTAPS outputs long.
- Reset mid-computation aborts with no `out_valid`. After release, the first sample behaves as after power-up.

## Configuration
- `FIR_SAT_EN` defined: result saturates to [−2^(DW−1), 2^(DW−1)−1].
- `FIR_SAT_EN` undefined: result wraps (low DW bits of the shifted accumulator).

## Test plan
- **Gain:** after reset, write `coeff[0]=0x4000`, then `sample_valid` with left=0x100000, right=0xF00000.
  - `out_valid` arrives 17 cycles later with `left_out=0x080000`, `right_out=0xF80000`.
- **Impulse / wrap:** set `coeff[k]=0x0100·(k+1)` for k=0..7, then feed left 0x008000 followed by zeros, one sample every 256 cycles.
  - Successive `left_out` = 0x000100·(k+1) for k=0..7; the 9th output is 0x000000.
- **Saturation:** set all coeffs to 0x7FFF and feed 8 samples with left=0x7FFFFF.
  - 8th `left_out` = 0x7FFFFF with `FIR_SAT_EN`, 0xFFF7F8 without.
- **Overrun:** `sample_valid` at t and t+5.
  - Exactly one `out_valid`, at t+17; `overrun=1` from t+6.
  - `overrun_clr` returns it to 0.
  - The next 9 outputs show the dropped sample never entered history.
- **Back-to-back / coeff guard:**
  - `sample_valid` coincident with `out_valid` → accepted, next `out_valid` 17 cycles later.
  - `coeff_we` while `busy` → coefficient unchanged.
- **Async reset:** drive reset low in MAC_R.
  - `busy`, `out_valid`, `left_out`, `right_out` and `overrun` go to 0 without waiting for a clk edge.
  - No `out_valid` after release; coefficients read back as zero (next output 0).
